// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM encoding and port identifiers for the memory arbiter.
// GPIO word addresses are listed for reference only; the arbiter forwards them like any other address.
package mem_arb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] GPIO_OUT_ADDR = 6'h3e;
  localparam logic [ADDR_W-1:0] GPIO_IN_ADDR  = 6'h3f;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_WB  = 1'b1
  } arb_port_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle for the arbiter: Wishbone slave side, CPU side and the single-port memory side.
// The arbiter uses the slave modport; the environment (requesters + memory) uses master.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [31:0]       wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic [DATA_W-1:0] wbs_dat_o;
  logic              wbs_ack_o;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina;
  logic [DATA_W-1:0] mem_douta;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output mem_wea, mem_addra, mem_dina,
    input  mem_douta
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  mem_wea, mem_addra, mem_dina,
    output mem_douta
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Tie-break between the Wishbone and CPU requesters.
// ARB_ROUND_ROBIN_EN: alternate on ties using a last-grant flag; otherwise Wishbone has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_req,
  input  logic      cpu_req,
  input  logic      grant_en,
  output arb_port_t grant_port
);

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_t last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= PORT_CPU;
    end else if (grant_en && (wb_req || cpu_req)) begin
      last_reg <= grant_port;
    end
  end

  always_comb begin
    grant_port = PORT_CPU;
    if (wb_req && cpu_req) begin
      grant_port = (last_reg == PORT_WB) ? PORT_CPU : PORT_WB;
    end else if (wb_req) begin
      grant_port = PORT_WB;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = clk ^ rst ^ grant_en ^ cpu_req;

  always_comb begin
    grant_port = wb_req ? PORT_WB : PORT_CPU;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a Wishbone slave window and a CPU port onto one single-port memory (IDLE/ACCESS/RESP).
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of Wishbone priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  arb_state_t state_reg, state_next;
  arb_port_t  owner_reg;
  arb_port_t  grant_port;
  logic       abort_reg;
  logic       wea_reg;
  logic [ADDR_W-1:0] addra_reg;
  logic [DATA_W-1:0] dina_reg;
  logic       wb_hit;
  logic       any_req;
  logic       unused_ok;

  // Byte-lane bits are irrelevant: every access is a full word.
  assign unused_ok = ^bus.wbs_adr_i[1:0];

  assign wb_hit  = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign any_req = wb_hit | bus.cpu_req;

  mem_arb_grant u_grant (
    .clk        (clk),
    .rst        (rst),
    .wb_req     (wb_hit),
    .cpu_req    (bus.cpu_req),
    .grant_en   (state_reg == ST_IDLE),
    .grant_port (grant_port)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.wbs_ack_o = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.wbs_dat_o = '0;
    bus.cpu_rdata = '0;
    case (state_reg)
      ST_IDLE:   if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP: begin
        state_next = ST_IDLE;
        if (owner_reg == PORT_WB) begin
          bus.wbs_ack_o = ~abort_reg;
          bus.wbs_dat_o = bus.mem_douta;
        end else begin
          bus.cpu_ack   = 1'b1;
          bus.cpu_rdata = bus.mem_douta;
        end
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory command is captured at the grant edge so it is stable for the whole ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wea_reg   <= 1'b0;
      addra_reg <= '0;
      dina_reg  <= '0;
      owner_reg <= PORT_CPU;
      abort_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            owner_reg <= grant_port;
            abort_reg <= 1'b0;
            if (grant_port == PORT_WB) begin
              wea_reg   <= bus.wbs_we_i;
              addra_reg <= bus.wbs_adr_i[7:2];
              dina_reg  <= bus.wbs_dat_i;
            end else begin
              wea_reg   <= bus.cpu_we;
              addra_reg <= bus.cpu_addr;
              dina_reg  <= bus.cpu_wdata;
            end
          end
        end
        ST_ACCESS: begin
          wea_reg <= 1'b0;
          if (owner_reg == PORT_WB && !bus.wbs_cyc_i) begin
            abort_reg <= 1'b1;
          end
        end
        default: wea_reg <= 1'b0;
      endcase
    end
  end

  assign bus.mem_wea   = wea_reg;
  assign bus.mem_addra = addra_reg;
  assign bus.mem_dina  = dina_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected acks/writes, negedge monitors pop and compare.
// Honours ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    bit          is_wb;
    logic [5:0]  addr;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  ack_t ack_q[$];
  wr_t  wr_q[$];
  logic [31:0] mem [64];

  mem_arb_if bus ();

  mem_arbiter #(.BASE_ADDR(32'h3000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Write-first single-port memory with registered read.
  always @(posedge clk) begin
    if (bus.mem_wea) begin
      mem[bus.mem_addra] <= bus.mem_dina;
      bus.mem_douta      <= bus.mem_dina;
    end else begin
      bus.mem_douta <= mem[bus.mem_addra];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ack monitor
  always @(negedge clk) begin
    if (bus.wbs_ack_o || bus.cpu_ack) begin
      if (ack_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got wb=%0b cpu=%0b expected none", bus.wbs_ack_o, bus.cpu_ack);
      end else begin
        ack_t e;
        e = ack_q.pop_front();
        chk("ack_wb", {31'b0, bus.wbs_ack_o}, {31'b0, e.is_wb});
        chk("ack_cpu", {31'b0, bus.cpu_ack}, {31'b0, !e.is_wb});
        chk("ack_addr", {26'b0, bus.mem_addra}, {26'b0, e.addr});
        chk("ack_data", e.is_wb ? bus.wbs_dat_o : bus.cpu_rdata, e.data);
        $display("ack port=%s addr=%h data=%h", e.is_wb ? "WB " : "CPU", bus.mem_addra,
                 e.is_wb ? bus.wbs_dat_o : bus.cpu_rdata);
      end
    end
  end

  // Memory write monitor
  always @(negedge clk) begin
    if (bus.mem_wea) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected none", bus.mem_addra, bus.mem_dina);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", {26'b0, bus.mem_addra}, {26'b0, w.addr});
        chk("wr_data", bus.mem_dina, w.data);
        $display("write addr=%h data=%h", bus.mem_addra, bus.mem_dina);
      end
    end
  end

  task automatic cpu_txn(input bit we, input logic [5:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd);
    int lat;
    ack_q.push_back('{is_wb: 1'b0, addr: a, data: exp_rd});
    if (we) wr_q.push_back('{addr: a, data: d});
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ack) break;
    end
    chk("cpu_latency", lat, 2);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_txn(input bit we, input logic [31:0] adr, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    int lat;
    logic [5:0] a;
    a = adr[7:2];
    ack_q.push_back('{is_wb: 1'b1, addr: a, data: exp_rd});
    if (we) wr_q.push_back('{addr: a, data: d});
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = d;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.wbs_ack_o) break;
    end
    chk("wb_latency", lat, 2);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb_cnt, cpu_cnt, target, cyc;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_douta = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_ack", {31'b0, bus.wbs_ack_o}, 0);
    chk("rst_cpu_ack", {31'b0, bus.cpu_ack}, 0);
    chk("rst_mem_wea", {31'b0, bus.mem_wea}, 0);
    chk("rst_mem_addra", {26'b0, bus.mem_addra}, 0);
    chk("rst_mem_dina", bus.mem_dina, 0);

    // CPU write then read-back
    cpu_txn(1'b1, 6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    cpu_txn(1'b0, 6'd5, 32'h0, 32'hDEAD_BEEF);
    // Wishbone read and write inside the window
    wb_txn(1'b0, 32'h3000_0014, 32'h0, 32'hDEAD_BEEF);
    wb_txn(1'b1, 32'h3000_0018, 32'h1234_5678, 32'h1234_5678);
    // GPIO address forwarded as an ordinary word
    cpu_txn(1'b1, GPIO_OUT_ADDR, 32'hA5A5_0001, 32'hA5A5_0001);

    // Out-of-window Wishbone write alongside a CPU read
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h3100_0000; bus.wbs_dat_i = 32'hFFFF_FFFF;
    cpu_txn(1'b0, 6'd6, 32'h0, 32'h1234_5678);
    repeat (4) begin
      @(negedge clk);
      chk("miss_no_ack", {31'b0, bus.wbs_ack_o}, 0);
      chk("miss_no_wea", {31'b0, bus.mem_wea}, 0);
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(negedge clk);

    // Wishbone write aborted during ACCESS: data lands, no ack
    wr_q.push_back('{addr: 6'd7, data: 32'hCAFE_F00D});
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h3000_001C; bus.wbs_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ack", {31'b0, bus.wbs_ack_o}, 0);
    end
    cpu_txn(1'b0, 6'd7, 32'h0, 32'hCAFE_F00D);

    // Reset during ACCESS of a CPU write
    wr_q.push_back('{addr: 6'd8, data: 32'h0BAD_0008});
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 6'd8; bus.cpu_wdata = 32'h0BAD_0008;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wea", {31'b0, bus.mem_wea}, 0);
    chk("midrst_ack", {31'b0, bus.cpu_ack}, 0);
    chk("midrst_addra", {26'b0, bus.mem_addra}, 0);
    rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    chk("midrst_ack_after", {31'b0, bus.cpu_ack}, 0);
    cpu_txn(1'b0, 6'd8, 32'h0, 32'h0BAD_0008);

    // Both ports requesting continuously
`ifdef ARB_ROUND_ROBIN_EN
    target = 4;
    for (int i = 0; i < 2; i++) begin
      ack_q.push_back('{is_wb: 1'b1, addr: 6'd5, data: 32'hDEAD_BEEF});
      ack_q.push_back('{is_wb: 1'b0, addr: 6'd6, data: 32'h1234_5678});
    end
`else
    target = 5;
    for (int i = 0; i < 4; i++)
      ack_q.push_back('{is_wb: 1'b1, addr: 6'd5, data: 32'hDEAD_BEEF});
    ack_q.push_back('{is_wb: 1'b0, addr: 6'd6, data: 32'h1234_5678});
`endif
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3000_0014;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 6'd6;
    wb_cnt = 0; cpu_cnt = 0; cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.wbs_ack_o) wb_cnt++;
      if (bus.cpu_ack) cpu_cnt++;
      if (bus.wbs_ack_o && wb_cnt == 4) begin
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      end
      if (wb_cnt + cpu_cnt >= target) begin
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.cpu_req = 1'b0;
        break;
      end
    end
    chk("contention_acks", wb_cnt + cpu_cnt, target);
    chk("contention_wb_acks", wb_cnt, (target == 4) ? 2 : 4);

    repeat (4) @(negedge clk);
    chk("ack_q_empty", ack_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000, Wishbone window base; bits [31:8] are decoded.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone slave cycle, strobe and write-enable.
REQ-005 wbs_adr_i  input  32  byte address; bits [7:2] are the word address.
REQ-006 wbs_dat_i  input  32  write data; wbs_dat_o  output  32  read data; wbs_ack_o  output  1  acknowledge.
REQ-007 cpu_req, cpu_we  input  1 each  CPU access request and write-enable.
REQ-008 cpu_addr  input  6  CPU word address; cpu_wdata  input  32  CPU write data.
REQ-009 cpu_ack  output  1  CPU acknowledge; cpu_rdata  output  32  CPU read data.
REQ-010 mem_wea  output  1  memory write-enable; mem_addra  output  6  memory address; mem_dina  output  32  memory write data.
REQ-011 mem_douta  input  32  memory read data, registered inside the memory with 1-cycle latency.

Function
REQ-012 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on grant, ACCESS->RESP always, RESP->IDLE always.
REQ-013 wb_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]); non-hit cycles are never acknowledged and never access memory.
REQ-014 In IDLE, a grant is issued when wb_hit or cpu_req is high; the winner's we/addr/wdata are registered onto mem_wea/mem_addra/mem_dina at that edge.
REQ-015 mem_wea is high only during ACCESS with a write grant, and 0 in every other state.
REQ-016 mem_addra and mem_dina hold their last value outside ACCESS.
REQ-017 RESP lasts exactly one cycle; the granted port's ack is high for that cycle only.
REQ-018 During RESP, wbs_dat_o or cpu_rdata equals mem_douta combinationally; on writes it reflects mem_douta as well (write-through echo).
REQ-019 Latency: request sampled at edge N, access during cycle N+1, ack during cycle N+2; next grant no earlier than edge N+3.
REQ-020 Requesters hold their request until ack; a request still high in the IDLE cycle after RESP is treated as a new transaction.
REQ-021 Abort: if the granted Wishbone requester drops wbs_cyc_i before RESP, the access still completes but wbs_ack_o is suppressed.
REQ-022 Simultaneous wb_hit and cpu_req: the winner is chosen by the policy in REQ-026/REQ-027; the loser waits without loss.
REQ-023 Addresses 6'h3e (GPIO out) and 6'h3f (GPIO in) are forwarded unchanged; the arbiter does not special-case them.
REQ-024 wbs_sel_i is not used; every write is a full 32-bit word.

Reset
REQ-025 On rst: state IDLE, mem_wea=0, mem_addra=0, mem_dina=0, wbs_ack_o=0, cpu_ack=0, last-grant flag=CPU; reset mid-transaction drops that transaction without an ack.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined: on a tie the port not granted last wins, and the last-grant flag updates on every grant.
REQ-027 Without ARB_ROUND_ROBIN_EN: Wishbone always wins a tie, and the last-grant flag is not implemented.

Structure
REQ-028 Package mem_arb_pkg holds ADDR_W=6, DATA_W=32, the FSM state encoding, and the GPIO address constants 6'h3e/6'h3f.
REQ-029 One sub-module, mem_arb_grant, holds the tie-break and last-grant logic; the FSM and datapath stay in mem_arbiter.

Verification
REQ-030 CPU write of 32'hDEAD_BEEF to addr 5, then a read of addr 5 -> mem_wea high 1 cycle with addr 5; read cpu_rdata=32'hDEAD_BEEF with cpu_ack in cycle N+2.
REQ-031 Wishbone read at 32'h3000_0014 -> mem_addra=5 in ACCESS; wbs_ack_o for 1 cycle with wbs_dat_o equal to the stored word.
REQ-032 Both ports request continuously -> with the macro, grants alternate WB,CPU,WB...; without it, WB is granted every time and the CPU waits until WB idles.
REQ-033 Wishbone access at 32'h3100_0000 -> no memory access and no ack; a CPU request in the same cycle is served normally.
REQ-034 rst asserted during ACCESS of a write -> no ack, mem_wea=0 the next cycle, FSM in IDLE; the following request is served with the normal latency.
REQ-035 wbs_cyc_i dropped during ACCESS -> the write lands in memory, wbs_ack_o stays 0.
